prince_round_ctrl: RTL and testbench

//  Round sequencer for the iterative (one-round-per-cycle) PRINCE core.

---
 rtl/prince_round_ctrl_if.sv | 49 ++++
 rtl/prince_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_prince_round_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prince_round_ctrl_if.sv
// rtl/prince_round_ctrl_if.sv - handshake and datapath-control bundle for the PRINCE round sequencer
interface prince_round_ctrl_if #(
    parameter int RC_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic            decrypt;
    logic            out_valid;
    logic            out_ready;
    logic            dp_load;
    logic            dp_en;
    logic [1:0]      dp_phase;
    logic            dp_final;
    logic [RC_W-1:0] rc_idx;
    logic            key_alpha;
    logic            busy;

    // Producer/consumer side: offers blocks, takes results, watches the controls.
    modport master (
        output in_valid,
        output decrypt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dp_load,
        input  dp_en,
        input  dp_phase,
        input  dp_final,
        input  rc_idx,
        input  key_alpha,
        input  busy
    );

    // Controller side: sequences the shared round datapath.
    modport slave (
        input  in_valid,
        input  decrypt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dp_load,
        output dp_en,
        output dp_phase,
        output dp_final,
        output rc_idx,
        output key_alpha,
        output busy
    );
endinterface

// File: rtl/prince_round_ctrl.sv
// rtl/prince_round_ctrl.sv - one-round-per-cycle PRINCE round sequencer (option macro: PRINCE_BACK2BACK_EN)
module prince_round_ctrl #(
    parameter int HALF_ROUNDS = 5,
    parameter int RC_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    prince_round_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_MID  = 3'd2,
        S_INV  = 3'd3,
        S_FIN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [RC_W-1:0] RC_ONE      = RC_W'(1);
    localparam logic [RC_W-1:0] RC_HALF     = RC_W'(HALF_ROUNDS);
    localparam logic [RC_W-1:0] RC_INV_FIRST = RC_W'(HALF_ROUNDS + 1);
    localparam logic [RC_W-1:0] RC_INV_LAST = RC_W'(2 * HALF_ROUNDS);
    localparam logic [RC_W-1:0] RC_FINAL    = RC_W'(2 * HALF_ROUNDS + 1);

    state_t          state;
    state_t          state_nx;
    logic [RC_W-1:0] cnt;
    logic [RC_W-1:0] cnt_nx;
    logic            alpha_q;
    logic            alpha_nx;
    logic            accept;

    logic            in_ready_c;
    logic            out_valid_c;
    logic            dp_load_c;
    logic            dp_en_c;
    logic [1:0]      dp_phase_c;
    logic            dp_final_c;
    logic [RC_W-1:0] rc_idx_c;

    // State, round counter and latched mode; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            alpha_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            alpha_q <= alpha_nx;
        end
    end

    // Next-state and datapath controls decoded from the current state and counter.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        alpha_nx    = alpha_q;
        accept      = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        dp_load_c   = 1'b0;
        dp_en_c     = 1'b0;
        dp_phase_c  = 2'b00;
        dp_final_c  = 1'b0;
        rc_idx_c    = '0;

        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                // A block offered while reset is still high is not taken.
                if (bus.in_valid && !rst) begin
                    accept = 1'b1;
                end
            end
            S_FWD: begin
                dp_en_c    = 1'b1;
                dp_phase_c = 2'b01;
                rc_idx_c   = cnt;
                if (cnt == RC_HALF) begin
                    state_nx = S_MID;
                end else begin
                    cnt_nx = cnt + RC_ONE;
                end
            end
            S_MID: begin
                // The middle layer uses no round constant.
                dp_en_c    = 1'b1;
                dp_phase_c = 2'b10;
                state_nx   = S_INV;
                cnt_nx     = RC_INV_FIRST;
            end
            S_INV: begin
                dp_en_c    = 1'b1;
                dp_phase_c = 2'b11;
                rc_idx_c   = cnt;
                if (cnt == RC_INV_LAST) begin
                    state_nx = S_FIN;
                end else begin
                    cnt_nx = cnt + RC_ONE;
                end
            end
            S_FIN: begin
                dp_en_c    = 1'b1;
                dp_final_c = 1'b1;
                dp_phase_c = 2'b11;
                rc_idx_c   = RC_FINAL;
                state_nx   = S_DONE;
            end
            S_DONE: begin
                // Result is held with dp_en low until the consumer takes it.
                out_valid_c = 1'b1;
`ifdef PRINCE_BACK2BACK_EN
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid && !rst) begin
                        accept = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end
                end
`else
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
`endif
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Accepting loads the input with whitening and latches the mode for the block.
        if (accept) begin
            dp_load_c  = 1'b1;
            dp_phase_c = 2'b00;
            rc_idx_c   = '0;
            alpha_nx   = bus.decrypt;
            state_nx   = S_FWD;
            cnt_nx     = RC_ONE;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.dp_load   = dp_load_c;
    assign bus.dp_en     = dp_en_c;
    assign bus.dp_phase  = dp_phase_c;
    assign bus.dp_final  = dp_final_c;
    assign bus.rc_idx    = rc_idx_c;
    assign bus.key_alpha = alpha_q;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_prince_round_ctrl.sv
// tb/tb_prince_round_ctrl.sv - randomized self-checking bench for prince_round_ctrl
module tb_prince_round_ctrl;

    localparam int HR   = 5;
    localparam int RC_W = 4;
    localparam int DONE_K = 2 * HR + 3;
`ifdef PRINCE_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prince_round_ctrl_if #(.RC_W(RC_W)) bus ();

    prince_round_ctrl #(
        .HALF_ROUNDS(HR),
        .RC_W       (RC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: position of the current block measured in cycles since accept.
    // -1 = idle, 1..2*HR+2 = working, 2*HR+3 = holding the result.
    int m_k     = -1;
    bit m_alpha = 1'b0;

    always @(negedge clk) begin : model_cmp
        bit e_ir, e_ov, e_load, e_en, e_fin, e_busy;
        int e_ph, e_rc;
        if (rst) begin
            m_k     = -1;
            m_alpha = 1'b0;
        end
        e_ir = 0; e_ov = 0; e_load = 0; e_en = 0; e_fin = 0;
        e_ph = 0; e_rc = 0;
        e_busy = (m_k > 0);
        if (m_k < 0) begin
            e_ir   = 1;
            e_load = bus.in_valid && !rst;
        end else if (m_k <= HR) begin
            e_en = 1; e_ph = 1; e_rc = m_k;
        end else if (m_k == HR + 1) begin
            e_en = 1; e_ph = 2;
        end else if (m_k <= 2 * HR + 1) begin
            e_en = 1; e_ph = 3; e_rc = m_k - 1;
        end else if (m_k == 2 * HR + 2) begin
            e_en = 1; e_fin = 1; e_ph = 3; e_rc = 2 * HR + 1;
        end else begin
            e_ov   = 1;
            e_ir   = B2B && bus.out_ready;
            e_load = B2B && bus.out_ready && bus.in_valid;
        end
        if (check_en) begin
            chk("in_ready",  bus.in_ready,  e_ir);
            chk("out_valid", bus.out_valid, e_ov);
            chk("dp_load",   bus.dp_load,   e_load);
            chk("dp_en",     bus.dp_en,     e_en);
            chk("dp_final",  bus.dp_final,  e_fin);
            chk("dp_phase",  bus.dp_phase,  e_ph);
            chk("rc_idx",    bus.rc_idx,    e_rc);
            chk("key_alpha", bus.key_alpha, m_alpha);
            chk("busy",      bus.busy,      e_busy);
        end
        if (!rst) begin
            if (e_load) begin
                m_k     = 1;
                m_alpha = bus.decrypt;
            end else if (m_k > 0 && m_k < DONE_K) begin
                m_k++;
            end else if (m_k == DONE_K && bus.out_ready) begin
                m_k = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block from IDLE; returns at +1 of cycle 1.
    task automatic start_block(input bit d);
        bus.in_valid = 1'b1;
        bus.decrypt  = d;
        #2;
        chk("accept_in_ready", bus.in_ready, 1'b1);
        chk("accept_dp_load",  bus.dp_load,  1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles from accept to out_valid while toggling decrypt.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            #2;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
            tick();
            bus.decrypt = 1'($urandom_range(0, 1));
        end
        chk("out_valid_seen", (lat > 0), 1'b1);
    endtask

    // Consumer takes the block after 'hold' refusing cycles.
    task automatic release_out(input int hold);
        for (int i = 0; i < hold; i++) tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    int exp_ph [12] = '{1, 1, 1, 1, 1, 2, 3, 3, 3, 3, 3, 3};
    int exp_rc [12] = '{1, 2, 3, 4, 5, 0, 6, 7, 8, 9, 10, 11};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int lat;
        int acc_t [$];
        bus.in_valid  = 1'b0;
        bus.decrypt   = 1'b0;
        bus.out_ready = 1'b0;
        check_en      = 1'b1;

        // Reset state
        tick();
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_rc_idx",    bus.rc_idx,    0);
        tick();
        rst = 1'b0;
        tick();

        // Encrypt block: result after 13 cycles
        start_block(1'b0);
        wait_out(lat);
        chk("latency_enc", lat, 13);
        chk("alpha_enc", bus.key_alpha, 1'b0);
        release_out(0);

        // Decrypt block: alpha latched for the whole block despite toggling decrypt
        start_block(1'b1);
        wait_out(lat);
        chk("latency_dec", lat, 13);
        chk("alpha_dec", bus.key_alpha, 1'b1);
        release_out(0);

        // Literal round sequence
        start_block(1'b0);
        for (int c = 1; c <= 12; c++) begin
            #2;
            chk("seq_phase", bus.dp_phase, exp_ph[c-1]);
            chk("seq_rc",    bus.rc_idx,   exp_rc[c-1]);
            chk("seq_final", bus.dp_final, (c == 12));
            tick();
        end
        #2;
        chk("seq_done_valid", bus.out_valid, 1'b1);

        // Consumer stalls for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            #2;
            chk("stall_out_valid", bus.out_valid, 1'b1);
            chk("stall_in_ready",  bus.in_ready,  1'b0);
            chk("stall_dp_en",     bus.dp_en,     1'b0);
        end
        tick();
        bus.out_ready = 1'b1;
        tick();
        #2;
        chk("release_busy",     bus.busy,     1'b0);
        chk("release_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b0;
        tick();

        // Reset in cycle 7 of a block
        start_block(1'b1);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("abort_in_ready",  bus.in_ready,  1'b1);
        chk("abort_busy",      bus.busy,      1'b0);
        chk("abort_key_alpha", bus.key_alpha, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            chk("abort_no_out_valid", bus.out_valid, 1'b0);
            tick();
        end

        // Randomized blocks with random gaps and consumer stalls
        for (int b = 0; b < 30; b++) begin
            repeat ($urandom_range(0, 3)) tick();
            start_block(1'($urandom_range(0, 1)));
            wait_out(lat);
            chk("latency_rand", lat, 13);
            release_out($urandom_range(0, 5));
        end

        // Continuous streaming: in_valid and out_ready held high
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && acc_t.size() < 5; c++) begin
            #2;
            if (bus.in_valid && bus.in_ready) acc_t.push_back(c);
            tick();
            bus.decrypt = 1'($urandom_range(0, 1));
        end
        chk("stream_accepts", (acc_t.size() == 5), 1'b1);
        for (int i = 1; i < acc_t.size(); i++) begin
            chk("stream_interval", acc_t[i] - acc_t[i-1], B2B ? 13 : 14);
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 40 && bus.busy; c++) tick();
        chk("drain_idle", bus.busy, 1'b0);
        bus.out_ready = 1'b0;
        tick();
        tick();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
